// File: rtl/video_pkg.sv
// video_pkg: shared mode encodings, sequencer state and mode-advance helpers.
//   bg_mode_t   - background source select driven to the video mux
//   tgt_mode_t  - overlay select; TGT_TEST exists for the mux but is never reached by button
//   seq_state_t - config sequencer state
package video_pkg;
    typedef enum logic [1:0] {BG_CAMERA, BG_CHANNEL, BG_THRESH, BG_YMASK} bg_mode_t;
    typedef enum logic [1:0] {TGT_NONE, TGT_CROSSHAIR, TGT_SPRITE, TGT_TEST} tgt_mode_t;
    typedef enum logic {ST_IDLE, ST_PENDING} seq_state_t;

    // Button cycle for overlays skips TGT_TEST and wraps back to TGT_NONE.
    function automatic tgt_mode_t next_tgt(input tgt_mode_t t);
        return (t == TGT_NONE) ? TGT_CROSSHAIR : (t == TGT_CROSSHAIR) ? TGT_SPRITE : TGT_NONE;
    endfunction

    // Background advances modulo 4; steps may be 0, 1 or 2 in one cycle.
    function automatic bg_mode_t bg_advance(input bg_mode_t b, input logic [1:0] steps);
        return bg_mode_t'(b + steps);
    endfunction
endpackage

// File: rtl/video_mode_sequencer_if.sv
// video_mode_sequencer_if: control inputs and video-mux config outputs of the sequencer.
//   btn_bg_in, btn_tgt_in - raw asynchronous buttons
//   auto_en_in            - level enable for automatic background cycling
//   frame_start_in        - one-cycle pulse at the first pixel of a frame
//   background_choice     - active background select
//   target_choice         - active overlay select
//   cfg_pending           - staged config differs from active config
//   cfg_update            - one-cycle pulse when the active config changes
interface video_mode_sequencer_if;
    logic       btn_bg_in;
    logic       btn_tgt_in;
    logic       auto_en_in;
    logic       frame_start_in;
    logic [1:0] background_choice;
    logic [1:0] target_choice;
    logic       cfg_pending;
    logic       cfg_update;

    modport master (
        output btn_bg_in, btn_tgt_in, auto_en_in, frame_start_in,
        input  background_choice, target_choice, cfg_pending, cfg_update
    );
    modport slave (
        input  btn_bg_in, btn_tgt_in, auto_en_in, frame_start_in,
        output background_choice, target_choice, cfg_pending, cfg_update
    );
endinterface

// File: rtl/button_debouncer.sv
// button_debouncer: 2-flop synchronizer, level debounce and one-cycle press pulse.
//   clk_pixel - pixel clock
//   rst_n     - asynchronous active-low reset
//   btn_in    - raw asynchronous button level
//   press     - one-cycle pulse on each accepted 0->1 of the debounced level
module button_debouncer #(
    parameter int unsigned CYCLES = 1_000_000
) (
    input  logic clk_pixel,
    input  logic rst_n,
    input  logic btn_in,
    output logic press
);
    localparam int unsigned DW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    logic          s1, s2, deb, armed, accept;
    logic [1:0]    vld;
    logic [DW-1:0] cnt;

    // The counter only runs while the synced level disagrees with the debounced one,
    // so any bounce back to the debounced level restarts the stability window.
    assign accept = (s2 != deb) && (cnt == DW'(CYCLES - 1));

    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            vld   <= 2'b00;
            deb   <= 1'b0;
            armed <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            s1    <= btn_in;
            s2    <= s1;
            vld   <= {vld[0], 1'b1};
            // A button held through reset must be seen released before it can press;
            // vld masks the reset value still sitting in the synchronizer.
            if (vld[1] && !s2)
                armed <= 1'b1;
            cnt   <= (s2 == deb || accept) ? '0 : cnt + 1'b1;
            if (accept)
                deb <= s2;
            press <= accept && s2 && armed;
        end
    end
endmodule

// File: rtl/video_mode_sequencer.sv
// video_mode_sequencer: stages background/overlay selections from buttons and an
// auto-cycle timer, and commits them to the video mux only at frame boundaries.
//   clk_pixel - pixel clock; all logic in this domain
//   rst_n     - asynchronous active-low reset
//   vif       - control inputs and config outputs (slave side)
module video_mode_sequencer
    import video_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned AUTO_FRAMES     = 120
) (
    input  logic                   clk_pixel,
    input  logic                   rst_n,
    video_mode_sequencer_if.slave  vif
);
    localparam int unsigned FW = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;

    logic          press_bg, press_tgt, auto_adv, diff, copy;
    logic          pending_q, update_q;
    logic [FW-1:0] frame_cnt;
    bg_mode_t      staged_bg, active_bg;
    tgt_mode_t     staged_tgt, active_tgt;
    seq_state_t    state, next_state;

    button_debouncer #(.CYCLES(DEBOUNCE_CYCLES)) u_bg_btn (
        .clk_pixel (clk_pixel),
        .rst_n     (rst_n),
        .btn_in    (vif.btn_bg_in),
        .press     (press_bg)
    );

    button_debouncer #(.CYCLES(DEBOUNCE_CYCLES)) u_tgt_btn (
        .clk_pixel (clk_pixel),
        .rst_n     (rst_n),
        .btn_in    (vif.btn_tgt_in),
        .press     (press_tgt)
    );

    // The AUTO_FRAMES-th frame_start acts as a background press in that same cycle.
    assign auto_adv = vif.auto_en_in && vif.frame_start_in && (frame_cnt == FW'(AUTO_FRAMES - 1));
    assign diff     = (staged_bg != active_bg) || (staged_tgt != active_tgt);

    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n)
            frame_cnt <= '0;
        else if (!vif.auto_en_in)
            frame_cnt <= '0;
        else if (vif.frame_start_in)
            frame_cnt <= auto_adv ? '0 : frame_cnt + 1'b1;
    end

    // Staged values advance on every press; a press coincident with the commit lands
    // after the copy because the copy samples the pre-edge staged value.
    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            staged_bg  <= BG_CAMERA;
            staged_tgt <= TGT_NONE;
        end else begin
            staged_bg  <= bg_advance(staged_bg, {1'b0, press_bg} + {1'b0, auto_adv});
            staged_tgt <= press_tgt ? next_tgt(staged_tgt) : staged_tgt;
        end
    end

    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = (diff && !(state == ST_PENDING && vif.frame_start_in)) ? ST_PENDING : ST_IDLE;
    end

    // Commit only when something actually differs, so a staged value walked back to
    // the active one never produces an update pulse.
    always_comb begin
        copy = (state == ST_PENDING) && vif.frame_start_in && diff;
    end

    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            active_bg  <= BG_CAMERA;
            active_tgt <= TGT_NONE;
            update_q   <= 1'b0;
            pending_q  <= 1'b0;
        end else begin
            active_bg  <= copy ? staged_bg : active_bg;
            active_tgt <= copy ? staged_tgt : active_tgt;
            update_q   <= copy;
            pending_q  <= (next_state == ST_PENDING);
        end
    end

    assign vif.background_choice = active_bg;
    assign vif.target_choice     = active_tgt;
    assign vif.cfg_pending       = pending_q;
    assign vif.cfg_update        = update_q;
endmodule

// File: doc/video_mode_sequencer.md
VIDEO_MODE_SEQUENCER -- requirements
Module: video_mode_sequencer

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1_000_000: consecutive stable cycles before a button level is accepted.
REQ-002 Parameter AUTO_FRAMES, default 120: frame_start pulses between automatic background advances.
REQ-003 clk_pixel  in  1  single pixel clock; all logic in this domain.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 btn_bg_in  in  1  raw asynchronous button; press requests next background mode.
REQ-006 btn_tgt_in  in  1  raw asynchronous button; press requests next target overlay.
REQ-007 auto_en_in  in  1  level; high enables automatic background cycling.
REQ-008 frame_start_in  in  1  single-cycle pulse at first pixel of each frame.
REQ-009 background_choice  out  2  active background select driven to the video mux.
REQ-010 target_choice  out  2  active overlay select driven to the video mux.
REQ-011 cfg_pending  out  1  high while staged config differs from active config.
REQ-012 cfg_update  out  1  one-cycle pulse in the cycle the active config changes.

Function
REQ-013 Each button SHALL pass a 2-flop synchronizer, then a debouncer: counter clears on any change of the synced level; synced level is accepted as debounced after DEBOUNCE_CYCLES consecutive equal cycles.
REQ-014 A 0->1 transition of a debounced level SHALL produce a one-cycle press pulse; releases produce nothing.
REQ-015 Background press: staged_bg = staged_bg + 1, mod 4 (00->01->10->11->00).
REQ-016 Target press: staged_tgt advances 00->01->10->00; 11 (test colour) is never reached via button.
REQ-017 Multiple presses within one frame SHALL each advance the staged value; staged values SHALL wrap without saturation.
REQ-018 Auto mode: frame counter increments on frame_start_in while auto_en_in high; on reaching AUTO_FRAMES it clears and advances staged_bg as one press; auto_en_in low clears the counter.
REQ-019 Auto advance and a background press in the same cycle SHALL advance staged_bg by 2.
REQ-020 FSM states: IDLE (staged == active), PENDING (staged != active).
REQ-021 IDLE -> PENDING in the cycle after staged first differs from active.
REQ-022 PENDING with frame_start_in at cycle t: active <= staged; new outputs and cfg_update high at t+1; state -> IDLE.
REQ-023 Outputs SHALL never change except at t+1 after a frame_start_in (no mid-frame tearing).
REQ-024 A press coincident with frame_start_in SHALL update staged after the copy, i.e. apply at the following frame.
REQ-025 If presses return staged to equal active (e.g. four bg presses) before frame_start, FSM SHALL return to IDLE and no cfg_update SHALL occur.
REQ-026 cfg_pending = (state == PENDING), registered.

Reset
REQ-027 rst_n low SHALL asynchronously force: background_choice 00, target_choice 00, staged values 00, cfg_update 0, cfg_pending 0, FSM IDLE, all counters 0, synchronizer and debounced levels 0.
REQ-028 Reset deassertion mid-frame SHALL resume in IDLE; a button held through reset SHALL NOT generate a press until released and pressed again.

Structure
REQ-029 Package video_pkg SHALL hold bg_mode_t {BG_CAMERA, BG_CHANNEL, BG_THRESH, BG_YMASK}, tgt_mode_t {TGT_NONE, TGT_CROSSHAIR, TGT_SPRITE, TGT_TEST}, and the FSM state enum.
REQ-030 Sub-module button_debouncer (synchronizer + debounce + press pulse) SHALL be instantiated twice.

Verification (DEBOUNCE_CYCLES=4, AUTO_FRAMES=3)
REQ-031 Reset: hold rst_n low mid-run -> all outputs 0 immediately, independent of clk_pixel.
REQ-032 btn_bg high 10 cycles, then frame_start -> cfg_pending rises; background_choice 00->01 and cfg_update pulse exactly one cycle after frame_start.
REQ-033 btn_bg glitch high 3 cycles -> no press; cfg_pending stays 0.
REQ-034 Three target presses in one frame -> target_choice 00->00 (wrap via 01,10,00), FSM back to IDLE, no cfg_update.
REQ-035 auto_en high, 6 frame_start pulses -> background_choice 01 after 3rd pulse's next frame, 10 after 6th's next frame.
REQ-036 bg press coincident with frame_start while PENDING at staged 01 -> 01 applied, then 10 applied at next frame_start.
